hazard_stall_gen: RTL

Hazard detection unit for the 5-stage MIPS pipeline (F/D/E/M/W). It produces the single `stall` request that the stall controller turns into PC/D-register enables and the E-register clear.
It keeps its own shadow of the destination register and remaining Tnew for the instructions in E and M. It compares these against the Tuse of the instruction in D.
It also owns the mult/div busy counter, so instructions that use HI/LO wait for the multiplier/divider.

---
 rtl/hazard_stall_gen.sv | 73 +++++++
 1 files changed

// File: rtl/hazard_stall_gen.sv
// Hazard detection for the 5-stage pipeline: shadows the E/M destination and Tnew,
// compares them against the Tuse of the D instruction and tracks the mult/div busy time.
module hazard_stall_gen #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_tuse_rs,
    input  logic [1:0] D_tuse_rt,
    input  logic [4:0] D_wa,
    input  logic [1:0] D_tnew,
    input  logic [1:0] D_md_op,
    input  logic       D_md_use,
    output logic       stall,
    output logic       md_busy
);

    logic [4:0]       e_wa_q, e_wa_d, m_wa_q, m_wa_d;
    logic [1:0]       e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic             haz_e_rs, haz_m_rs, haz_e_rt, haz_m_rt, md_stall;

    // A Tuse of 3 never satisfies Tnew > Tuse, so "not read" needs no special case.
    assign haz_e_rs = (D_rs != 5'd0) && (e_wa_q == D_rs) && (e_tnew_q > D_tuse_rs);
    assign haz_m_rs = (D_rs != 5'd0) && (m_wa_q == D_rs) && (m_tnew_q > D_tuse_rs);
    assign haz_e_rt = (D_rt != 5'd0) && (e_wa_q == D_rt) && (e_tnew_q > D_tuse_rt);
    assign haz_m_rt = (D_rt != 5'd0) && (m_wa_q == D_rt) && (m_tnew_q > D_tuse_rt);

    assign md_busy  = (md_cnt_q != '0);
    assign md_stall = D_md_use && md_busy;
    assign stall    = !reset && (haz_e_rs || haz_m_rs || haz_e_rt || haz_m_rt || md_stall);

    always_comb begin
        m_wa_d   = e_wa_q;
        m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
        e_wa_d   = 5'd0;
        e_tnew_d = 2'd0;
        if (!stall) begin
            e_wa_d   = D_wa;
            e_tnew_d = (D_wa == 5'd0) ? 2'd0 : D_tnew;
        end

        md_cnt_d = md_cnt_q;
        if (!stall && D_md_op == 2'b01) begin
            md_cnt_d = CNT_W'(MULT_CYCLES);
        end else if (!stall && D_md_op == 2'b10) begin
            md_cnt_d = CNT_W'(DIV_CYCLES);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_wa_q   <= 5'd0;
            e_tnew_q <= 2'd0;
            m_wa_q   <= 5'd0;
            m_tnew_q <= 2'd0;
            md_cnt_q <= '0;
        end else begin
            e_wa_q   <= e_wa_d;
            e_tnew_q <= e_tnew_d;
            m_wa_q   <= m_wa_d;
            m_tnew_q <= m_tnew_d;
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule
